ifu_lsu_mem_arbiter: RTL
========================

Name: ifu_lsu_mem_arbiter

Overview:
Shares one memory port between instruction fetch (IFU) and load/store (LSU) once the core leaves single-cycle mode. Serialises transactions with at most one outstanding and routes each response back to the requester that issued it. Sits between the core front/back end and the memory/DPI bridge.

Parameters:
AW, 32, address width (PC is 32-bit; reset PC 0x80000000).
DW, 64, data width.
MW, DW/8, write byte-mask width; derived, not overridable.

Ports:
clk  in  1  clock
rst  in  1  reset
if_req  in  1  IFU request; held with if_addr until if_gnt
if_addr  in  AW  fetch address
if_gnt  out  1  IFU request accepted this cycle
if_rvalid  out  1  IFU response valid
if_rdata  out  DW  IFU read data
ls_req  in  1  LSU request; held with its fields until ls_gnt
ls_we  in  1  1 = store, 0 = load
ls_addr  in  AW  load/store address
ls_wdata  in  DW  store data
ls_wmask  in  MW  store byte mask
ls_gnt  out  1  LSU request accepted this cycle
ls_rvalid  out  1  LSU response valid (load data or store ack)
ls_rdata  out  DW  LSU read data
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_wmask  out  MW  memory byte mask
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  memory response/ack valid
mem_rdata  in  DW  memory read data
owner  out  2  00 none, 01 IFU, 10 LSU
proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset rst, synchronous, active-high; clock clk. Reset: state IDLE, owner 00, proto_err 0, all gnt/rvalid/mem_req 0, rdata outputs 0, priority pointer favours LSU.
- States: IDLE, WAIT_IF, WAIT_LS.
- IDLE: pick a winner among asserted requests; mem_* driven combinationally from winner; mem_req = winner present. IFU selected: mem_we=0, mem_wmask=0, mem_wdata=0.
- Fixed priority (default): LSU wins over IFU.
- Grant: if_gnt/ls_gnt = mem_gnt & mem_req & selected, same cycle. On grant: IDLE -> WAIT_IF or WAIT_LS; owner updates next cycle.
- No grant while in WAIT_*; mem_req=0 there.
- WAIT_x: mem_rvalid forwarded combinationally: x_rvalid = mem_rvalid, x_rdata = mem_rdata, same cycle; the other requester's rvalid stays 0. On mem_rvalid -> IDLE.
- Stores complete with mem_rvalid as ack; ls_rdata then forwards mem_rdata, meaning undefined.
- Throughput: at most one transaction per 2 cycles (grant cycle, response cycle minimum; no issue in response cycle).
- Requester dropping req before gnt: legal; selection re-evaluated each IDLE cycle.
- mem_rvalid in IDLE: ignored (no x_rvalid), proto_err set; held until rst.
- Reset mid-transaction: back to IDLE immediately; a response arriving afterwards is treated as stray (proto_err=1); benches deassert mem_rvalid around reset.
- owner = 01 in WAIT_IF, 10 in WAIT_LS, 00 in IDLE.

Optional Feature:
ARB_RR_EN: defined -> round-robin; 1-bit pointer flips to the non-winner after each grant, and on simultaneous requests the pointed-to requester wins. Undefined -> fixed LSU priority, no pointer flop.

Decomposition:
- Shared package: state encoding (IDLE/WAIT_IF/WAIT_LS), owner codes (OWN_NONE/OWN_IF/OWN_LS), RESET_PC 32'h80000000 constant for benches.
- Sub-module arb_pick2: combinational 2-way picker (req0, req1, ptr -> onehot grant), RR/fixed selected by macro.

Test Plan:
- IFU only: if_req, if_addr=0x80000000, mem_gnt=1 -> if_gnt same cycle; mem_rvalid 2 cycles later with mem_rdata=0x00100073 -> if_rvalid=1, if_rdata=0x00100073, owner 01 -> 00.
- Simultaneous req, fixed: ls_req load 0x80001000 + if_req -> ls_gnt first; if_gnt only in IDLE after ls_rvalid; ARB_RR_EN build: next simultaneous pair grants IFU.
- Store: ls_we=1, ls_wmask=0x0F, ls_wdata=0xDEADBEEF -> mem_we=1, mem_wmask=0x0F, mem_wdata=0xDEADBEEF; ack -> ls_rvalid=1, if_rvalid=0.
- Backpressure: mem_gnt=0 for 5 cycles -> no gnt, mem_addr stable, state IDLE; mem_gnt=1 -> grant that cycle.
- Stray response: mem_rvalid in IDLE -> no rvalid outputs, proto_err=1 until rst.
- Reset in WAIT_LS -> next cycle owner=00, mem_req follows pending request; late mem_rvalid -> proto_err=1.

Source files
------------

// File: rtl/ifu_lsu_mem_arbiter_pkg.sv
// ifu_lsu_mem_arbiter_pkg
//   Shared types and constants for the IFU/LSU memory-port arbiter:
//   FSM state encoding, owner codes and the core reset PC.
package ifu_lsu_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWaitIf = 2'd1,
        StWaitLs = 2'd2
    } arb_state_e;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IF   = 2'b01;
    localparam logic [1:0] OWN_LS   = 2'b10;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    // Owner code reported for a given arbiter state.
    function automatic logic [1:0] state_owner(arb_state_e st);
        logic [1:0] own;
        own = OWN_NONE;
        unique case (st)
            StWaitIf: own = OWN_IF;
            StWaitLs: own = OWN_LS;
            default:  own = OWN_NONE;
        endcase
        return own;
    endfunction

endpackage

// File: rtl/ifu_lsu_mem_arbiter_if.sv
// ifu_lsu_mem_arbiter_if
//   Bundles the IFU request/response, LSU request/response and memory-port
//   signals of the arbiter.
//   Modports:
//     slave  - arbiter view (takes requests, drives grants/responses and mem_*)
//     master - environment view (requesters and memory bridge)
//   Parameters: AW address width, DW data width; MW = DW/8 is derived.
interface ifu_lsu_mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 64
);
    localparam int unsigned MW = DW / 8;

    // IFU side
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    // LSU side
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic [MW-1:0] ls_wmask;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;

    // Memory port
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_wmask,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_wmask,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/ifu_lsu_mem_arbiter_arb_pick2.sv
// arb_pick2
//   Combinational two-way picker producing a one-hot (or zero) grant vector.
//   Ports: req0_i/req1_i requests, ptr_i favoured requester (ARB_RR_EN only),
//          gnt_o[0]/gnt_o[1] winner.
//   Macro ARB_RR_EN: defined -> pointer-based round-robin on ties;
//                    undefined -> fixed priority, req0 wins.
module arb_pick2 (
    input  logic       req0_i,
    input  logic       req1_i,
`ifdef ARB_RR_EN
    input  logic       ptr_i,
`endif
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (req0_i && req1_i) begin
`ifdef ARB_RR_EN
            gnt_o = ptr_i ? 2'b10 : 2'b01;
`else
            gnt_o = 2'b01;
`endif
        end else if (req0_i) begin
            gnt_o = 2'b01;
        end else if (req1_i) begin
            gnt_o = 2'b10;
        end
    end

endmodule

// File: rtl/ifu_lsu_mem_arbiter.sv
// ifu_lsu_mem_arbiter
//   Shares one memory port between instruction fetch and load/store with at
//   most one transaction outstanding; responses go back to the issuer.
//   Ports:
//     clk, rst   - clock, synchronous active-high reset
//     bus        - slave modport of ifu_lsu_mem_arbiter_if (IFU, LSU, memory)
//     owner      - 00 none, 01 IFU, 10 LSU (follows the registered state)
//     proto_err  - sticky: response seen with nothing outstanding
//   Macro ARB_RR_EN: defined -> round-robin on simultaneous requests;
//                    undefined -> LSU always wins, no pointer flop.
module ifu_lsu_mem_arbiter
    import ifu_lsu_mem_arbiter_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    ifu_lsu_mem_arbiter_if.slave  bus,
    output logic [1:0]            owner,
    output logic                  proto_err
);

    localparam int unsigned MW = DW / 8;

    arb_state_e state_q, state_d;
    logic       proto_err_q, proto_err_d;
    logic [1:0] pick;
    logic       idle, sel_ls, sel_if;
    logic       ls_gnt, if_gnt;

    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;
    logic [MW-1:0] wmask_mux;

`ifdef ARB_RR_EN
    // 0 favours LSU, 1 favours IFU
    logic ptr_q, ptr_d;
`endif

    assign idle = (state_q == StIdle);

    // req0 is the LSU so the fixed-priority build favours it
    arb_pick2 u_pick (
        .req0_i (bus.ls_req),
        .req1_i (bus.if_req),
`ifdef ARB_RR_EN
        .ptr_i  (ptr_q),
`endif
        .gnt_o  (pick)
    );

    // Nothing is issued outside IDLE, including the response cycle
    assign sel_ls = idle & pick[0];
    assign sel_if = idle & pick[1];

    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        wmask_mux = '0;
        if (sel_ls) begin
            addr_mux  = bus.ls_addr;
            wdata_mux = bus.ls_wdata;
            wmask_mux = bus.ls_wmask;
        end else if (sel_if) begin
            addr_mux  = bus.if_addr;
        end
    end

    assign bus.mem_req   = sel_ls | sel_if;
    assign bus.mem_we    = sel_ls & bus.ls_we;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
    assign bus.mem_wmask = wmask_mux;

    assign ls_gnt     = sel_ls & bus.mem_gnt;
    assign if_gnt     = sel_if & bus.mem_gnt;
    assign bus.ls_gnt = ls_gnt;
    assign bus.if_gnt = if_gnt;

    // Responses are forwarded in the same cycle to the current owner only
    assign bus.if_rvalid = (state_q == StWaitIf) & bus.mem_rvalid;
    assign bus.ls_rvalid = (state_q == StWaitLs) & bus.mem_rvalid;
    assign bus.if_rdata  = (state_q == StWaitIf) ? bus.mem_rdata : '0;
    assign bus.ls_rdata  = (state_q == StWaitLs) ? bus.mem_rdata : '0;

    assign owner     = state_owner(state_q);
    assign proto_err = proto_err_q;

    always_comb begin
        state_d     = state_q;
        proto_err_d = proto_err_q;
        unique case (state_q)
            StIdle: begin
                if (ls_gnt) begin
                    state_d = StWaitLs;
                end else if (if_gnt) begin
                    state_d = StWaitIf;
                end
                // A response with nothing outstanding is a stray
                if (bus.mem_rvalid) begin
                    proto_err_d = 1'b1;
                end
            end
            StWaitIf, StWaitLs: begin
                if (bus.mem_rvalid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef ARB_RR_EN
    // Point at the loser after each grant
    always_comb begin
        ptr_d = ptr_q;
        if (ls_gnt) begin
            ptr_d = 1'b1;
        end else if (if_gnt) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule
